// File: rtl/pipe_reg_chain_pkg.sv
// rtl/pipe_reg_chain_pkg.sv - shared constants and helpers for pipe_reg_chain
// Optional occupancy counter is enabled by defining PIPE_REG_CHAIN_OCC_EN.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Counter must hold 0..depth inclusive; never narrower than one bit.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int tap_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// rtl/pipe_reg_chain_if.sv - data/control bundle between a pipeline and its user
// Carries the occ count only when PIPE_REG_CHAIN_OCC_EN is defined.
interface pipe_reg_chain_if #(
  parameter int WIDTH = pipe_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = pipe_pkg::DEFAULT_DEPTH
);
  logic                     en;
  logic                     flush;
  logic [WIDTH-1:0]         d;
  logic                     d_valid;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;
  logic [WIDTH*DEPTH-1:0]   taps;
  logic [DEPTH-1:0]         taps_valid;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [pipe_pkg::occ_width(DEPTH)-1:0] occ;

  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid, taps, taps_valid, occ
  );

  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid, taps, taps_valid, occ
  );
`else
  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid, taps, taps_valid
  );

  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid, taps, taps_valid
  );
`endif

endinterface

// File: rtl/pipe_reg_chain_stage.sv
// rtl/pipe_reg_chain_stage.sv - one enabled register stage with valid bit
// Priority: reset > flush > en > hold.
module pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Flush only drops the valid bit; data is left as-is.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage WIDTH-bit delay line with valids, stall, flush
// Define PIPE_REG_CHAIN_OCC_EN to add the registered occupancy count (bus.occ).
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              reset_n,
  pipe_reg_chain_if.slave  bus
);

  logic [WIDTH-1:0]       stage_q [DEPTH];
  logic [DEPTH-1:0]       stage_v;
  logic [WIDTH*DEPTH-1:0] taps_w;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] sd;
    logic             sv;

    if (i == 0) begin : g_head
      assign sd = bus.d;
      assign sv = bus.d_valid;
    end else begin : g_link
      assign sd = stage_q[i-1];
      assign sv = stage_v[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (bus.en),
      .flush   (bus.flush),
      .d       (sd),
      .d_valid (sv),
      .q       (stage_q[i]),
      .q_valid (stage_v[i])
    );
  end

  always_comb begin
    taps_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      taps_w[tap_lo(i, WIDTH) +: WIDTH] = stage_q[i];
    end
  end

  assign bus.taps       = taps_w;
  assign bus.taps_valid = stage_v;
  assign bus.q          = stage_q[DEPTH-1];
  assign bus.q_valid    = stage_v[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic [OW-1:0] occ_r;

  // Incremental: one entry in at stage 0, one entry out of the last stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_r <= '0;
    end else if (bus.flush) begin
      occ_r <= '0;
    end else if (bus.en) begin
      occ_r <= occ_r + OW'(bus.d_valid) - OW'(stage_v[DEPTH-1]);
    end
  end

  assign bus.occ = occ_r;

  occ_matches_valids: assert property (@(posedge clk)
    int'(occ_r) == $countones(stage_v));
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed bench for pipe_reg_chain (DEPTH=4 and DEPTH=1)
// Occupancy checks are compiled in when PIPE_REG_CHAIN_OCC_EN is defined.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(4)) bus ();
  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

  pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
`ifdef PIPE_REG_CHAIN_OCC_EN
    chk("occ_popcount", 64'(bus.occ), 64'($countones(bus.taps_valid)));
`endif
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef PIPE_REG_CHAIN_OCC_EN
    chk(tag, 64'(bus.occ), 64'(exp));
`else
    if (exp < 0) $display("occ %s unused", tag);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    bus.en = 1'b0; bus.flush = 1'b0; bus.d = '0; bus.d_valid = 1'b0;
    bus1.en = 1'b0; bus1.flush = 1'b0; bus1.d = '0; bus1.d_valid = 1'b0;

    // Reset for two edges
    step(); step();
    chk("rst_taps", 64'(bus.taps), 64'h A5A5A5A5);
    chk("rst_tv", 64'(bus.taps_valid), 64'h0);
    chk("rst_qv", 64'(bus.q_valid), 64'h0);
    chk("rst_q", 64'(bus.q), 64'hA5);
    chk("rst_q1", 64'(bus1.q), 64'h3C);
    chk("rst_qv1", 64'(bus1.q_valid), 64'h0);
    chk_occ("rst_occ", 0);
    reset_n = 1'b1;

    // Streaming: d=1 reaches q on the 4th edge
    bus.en = 1'b1; bus.d_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.d = 8'(k);
      step();
      chk_occ("fill_occ", k);
      if (k < 4) chk("lat_early_qv", 64'(bus.q_valid), 64'h0);
    end
    chk("lat_q1", 64'(bus.q), 64'h01);
    chk("lat_qv1", 64'(bus.q_valid), 64'h1);
    chk("lat_taps", 64'(bus.taps), 64'h01020304);
    chk("lat_tv", 64'(bus.taps_valid), 64'hF);
    bus.d = 8'h05; step();
    chk("lat_q2", 64'(bus.q), 64'h02);
    chk_occ("full_occ", 4);
    bus.d = 8'h06; step();
    chk("lat_q3", 64'(bus.q), 64'h03);

    // Stall plus bubble
    bus.d = 8'h11; bus.d_valid = 1'b1; step();
    bus.d = 8'h22; bus.d_valid = 1'b0; step();
    bus.d = 8'h33; bus.d_valid = 1'b1; step();
    chk("bub_taps", 64'(bus.taps), 64'h06112233);
    chk("bub_tv", 64'(bus.taps_valid), 64'hD);
    bus.en = 1'b0; bus.d = 8'h99; bus.d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_taps", 64'(bus.taps), 64'h06112233);
      chk("stall_tv", 64'(bus.taps_valid), 64'hD);
    end
    chk_occ("stall_occ", 3);
    bus.en = 1'b1; bus.d = 8'h00; bus.d_valid = 1'b0;
    step();
    chk("res_q11", 64'(bus.q), 64'h11);
    chk("res_qv11", 64'(bus.q_valid), 64'h1);
    step();
    chk("res_q22", 64'(bus.q), 64'h22);
    chk("res_qv22", 64'(bus.q_valid), 64'h0);
    step();
    chk("res_q33", 64'(bus.q), 64'h33);
    chk("res_qv33", 64'(bus.q_valid), 64'h1);
    chk_occ("res_occ", 1);

    // Flush beats en; 0x77 must never enter
    for (int k = 1; k <= 4; k++) begin
      bus.d = 8'(8'h40 + k); bus.d_valid = 1'b1; step();
    end
    chk("pre_flush_taps", 64'(bus.taps), 64'h41424344);
    chk("pre_flush_tv", 64'(bus.taps_valid), 64'hF);
    bus.flush = 1'b1; bus.d = 8'h77; step();
    chk("flush_tv", 64'(bus.taps_valid), 64'h0);
    chk("flush_taps", 64'(bus.taps), 64'h41424344);
    chk("flush_qv", 64'(bus.q_valid), 64'h0);
    chk_occ("flush_occ", 0);
    bus.flush = 1'b0; bus.en = 1'b0; step();
    chk("post_flush_taps", 64'(bus.taps), 64'h41424344);

    // Mid-stream reset with en=1
    bus.en = 1'b1; bus.d_valid = 1'b1;
    bus.d = 8'h51; step();
    bus.d = 8'h52; step();
    bus.d = 8'h53; step();
    chk("mid_taps", 64'(bus.taps), 64'h44515253);
    chk("mid_tv", 64'(bus.taps_valid), 64'h7);
    reset_n = 1'b0; bus.d = 8'h54; step();
    chk("mrst_taps", 64'(bus.taps), 64'hA5A5A5A5);
    chk("mrst_tv", 64'(bus.taps_valid), 64'h0);
    chk_occ("mrst_occ", 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.d = 8'(8'h60 + k); step();
      chk_occ("refill_occ", k);
      if (k < 4) chk("restart_early_qv", 64'(bus.q_valid), 64'h0);
    end
    chk("restart_q", 64'(bus.q), 64'h61);
    chk("restart_qv", 64'(bus.q_valid), 64'h1);
    chk("restart_taps", 64'(bus.taps), 64'h61626364);
    bus.d = 8'h65; step();
    chk_occ("sat_occ", 4);
    bus.flush = 1'b1; step();
    chk_occ("sat_flush_occ", 0);
    bus.flush = 1'b0; bus.en = 1'b0;

    // DEPTH=1 boundary
    bus1.en = 1'b1; bus1.d = 8'h5A; bus1.d_valid = 1'b1; step();
    chk("d1_q", 64'(bus1.q), 64'h5A);
    chk("d1_qv", 64'(bus1.q_valid), 64'h1);
    bus1.en = 1'b0; bus1.d = 8'h00; bus1.d_valid = 1'b0; step();
    chk("d1_hold", 64'(bus1.q), 64'h5A);
    chk("d1_hold_qv", 64'(bus1.q_valid), 64'h1);
    bus1.en = 1'b1; bus1.d = 8'hC3; bus1.d_valid = 1'b0; step();
    chk("d1_q2", 64'(bus1.q), 64'hC3);
    chk("d1_qv2", 64'(bus1.q_valid), 64'h0);
    bus1.flush = 1'b1; bus1.d = 8'hEE; bus1.d_valid = 1'b1; step();
    chk("d1_flush_q", 64'(bus1.q), 64'hC3);
    chk("d1_flush_qv", 64'(bus1.q_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
